// File: rtl/rhythm_judge.sv
// Timing judge for the rhythm game: grades a button press against a note's beat
// as PERFECT, GOOD or MISS and keeps saturating score and combo counters.
module rhythm_judge #(
  parameter int LEAD_CYC    = 25_000_000,
  parameter int PERFECT_WIN = 1_250_000,
  parameter int GOOD_WIN    = 5_000_000,
  parameter int CNT_W       = 26,
  parameter int PERFECT_PTS = 100,
  parameter int GOOD_PTS    = 50,
  parameter int SCORE_W     = 16,
  parameter int COMBO_W     = 10
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_fPush,
  input  logic               i_NoteSpawn,
  input  logic               i_Clear,
  output logic               o_ResultValid,
  output logic [1:0]         o_Result,
  output logic [SCORE_W-1:0] o_Score,
  output logic [COMBO_W-1:0] o_Combo,
  output logic [COMBO_W-1:0] o_MaxCombo,
  output logic               o_Overrun
);

  typedef enum logic {S_IDLE, S_TRACK} state_t;

  localparam logic [1:0] RES_NONE    = 2'd0;
  localparam logic [1:0] RES_PERFECT = 2'd1;
  localparam logic [1:0] RES_GOOD    = 2'd2;
  localparam logic [1:0] RES_MISS    = 2'd3;

  // Window edges expressed as absolute tracking-counter values
  localparam logic [CNT_W-1:0] PERF_LO = CNT_W'(LEAD_CYC - PERFECT_WIN);
  localparam logic [CNT_W-1:0] PERF_HI = CNT_W'(LEAD_CYC + PERFECT_WIN);
  localparam logic [CNT_W-1:0] GOOD_LO = CNT_W'(LEAD_CYC - GOOD_WIN);
  localparam logic [CNT_W-1:0] EXPIRE  = CNT_W'(LEAD_CYC + GOOD_WIN);

  localparam logic [SCORE_W:0] PERF_ADD = (SCORE_W+1)'(PERFECT_PTS);
  localparam logic [SCORE_W:0] GOOD_ADD = (SCORE_W+1)'(GOOD_PTS);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic               judge_valid;
  logic [1:0]         judge_code;
  logic [SCORE_W:0]   score_sum;
  logic [COMBO_W-1:0] combo_inc;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (i_Clear) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (i_NoteSpawn) state_next = S_TRACK;
        S_TRACK: if (judge_valid) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Early presses (below GOOD_LO) fall through untouched; a press in the expiry cycle wins over MISS
  always_comb begin
    judge_valid = 1'b0;
    judge_code  = RES_NONE;
    score_sum   = {1'b0, o_Score};
    combo_inc   = (o_Combo == {COMBO_W{1'b1}}) ? o_Combo : o_Combo + 1'b1;
    if (!i_Clear && state == S_TRACK) begin
      if (i_fPush && cnt >= PERF_LO && cnt <= PERF_HI) begin
        judge_valid = 1'b1;
        judge_code  = RES_PERFECT;
        score_sum   = {1'b0, o_Score} + PERF_ADD;
      end else if (i_fPush && cnt >= GOOD_LO) begin
        judge_valid = 1'b1;
        judge_code  = RES_GOOD;
        score_sum   = {1'b0, o_Score} + GOOD_ADD;
      end else if (cnt == EXPIRE) begin
        judge_valid = 1'b1;
        judge_code  = RES_MISS;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt <= '0;
    end else if (state == S_TRACK && state_next == S_TRACK) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_ResultValid <= 1'b0;
      o_Result      <= RES_NONE;
      o_Score       <= '0;
      o_Combo       <= '0;
      o_MaxCombo    <= '0;
      o_Overrun     <= 1'b0;
    end else if (i_Clear) begin
      o_ResultValid <= 1'b0;
      o_Result      <= RES_NONE;
      o_Score       <= '0;
      o_Combo       <= '0;
      o_MaxCombo    <= '0;
      o_Overrun     <= 1'b0;
    end else begin
      o_ResultValid <= judge_valid;
      if (judge_valid) begin
        o_Result <= judge_code;
        if (judge_code == RES_MISS) begin
          o_Combo <= '0;
        end else begin
          o_Score <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
          o_Combo <= combo_inc;
          if (combo_inc > o_MaxCombo) o_MaxCombo <= combo_inc;
        end
      end
      if (state == S_TRACK && i_NoteSpawn) o_Overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rhythm_judge.sv
// Directed bench for rhythm_judge: a cycle-time model of note beats checked every
// cycle, plus literal expectations for each scenario.
module tb_rhythm_judge;

  localparam int LEAD_CYC    = 20;
  localparam int PERFECT_WIN = 2;
  localparam int GOOD_WIN    = 5;
  localparam int CNT_W       = 6;
  localparam int PERFECT_PTS = 100;
  localparam int GOOD_PTS    = 50;
  localparam int SCORE_W     = 16;
  localparam int COMBO_W     = 10;
  localparam int SCORE_MAX   = 65535;
  localparam int COMBO_MAX   = 1023;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               push = 1'b0;
  logic               spawn = 1'b0;
  logic               clear = 1'b0;
  logic               result_valid;
  logic [1:0]         result;
  logic [SCORE_W-1:0] score;
  logic [COMBO_W-1:0] combo;
  logic [COMBO_W-1:0] max_combo;
  logic               overrun;

  int vectors = 0;
  int miscompares = 0;

  rhythm_judge #(
    .LEAD_CYC(LEAD_CYC), .PERFECT_WIN(PERFECT_WIN), .GOOD_WIN(GOOD_WIN), .CNT_W(CNT_W),
    .PERFECT_PTS(PERFECT_PTS), .GOOD_PTS(GOOD_PTS), .SCORE_W(SCORE_W), .COMBO_W(COMBO_W)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_fPush(push), .i_NoteSpawn(spawn), .i_Clear(clear),
    .o_ResultValid(result_valid), .o_Result(result), .o_Score(score), .o_Combo(combo),
    .o_MaxCombo(max_combo), .o_Overrun(overrun)
  );

  always #5 clk = ~clk;

  // Model: a note's beat is an absolute cycle number; grading uses the signed distance to it
  int cyc = 0;
  int beat = 0;
  int off = 0;
  bit active = 0;
  bit m_rv = 0;
  int m_res = 0;
  int m_score = 0;
  int m_combo = 0;
  int m_max = 0;
  bit m_ovr = 0;

  function automatic void grade(input int code);
    m_rv  = 1;
    m_res = code;
    if (code == 3) begin
      m_combo = 0;
    end else begin
      m_score = m_score + ((code == 1) ? PERFECT_PTS : GOOD_PTS);
      if (m_score > SCORE_MAX) m_score = SCORE_MAX;
      if (m_combo < COMBO_MAX) m_combo = m_combo + 1;
      if (m_combo > m_max) m_max = m_combo;
    end
  endfunction

  function automatic void model_zero();
    active = 0; m_rv = 0; m_res = 0; m_score = 0; m_combo = 0; m_max = 0; m_ovr = 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_zero();
    end else begin
      cyc = cyc + 1;
      m_rv = 0;
      if (clear) begin
        model_zero();
      end else if (active) begin
        off = cyc - beat;
        if (spawn) m_ovr = 1;
        if (push && off >= -GOOD_WIN) begin
          grade(((off < 0 ? -off : off) <= PERFECT_WIN) ? 1 : 2);
          active = 0;
        end else if (off == GOOD_WIN) begin
          grade(3);
          active = 0;
        end
      end else if (spawn) begin
        active = 1;
        beat = cyc + 1 + LEAD_CYC;
      end
    end
  end

  always @(negedge clk) begin
    vectors = vectors + 1;
    if (result_valid !== m_rv || int'(result) != m_res || int'(score) != m_score ||
        int'(combo) != m_combo || int'(max_combo) != m_max || overrun !== m_ovr) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL cycle_model t=%0t got v=%0b r=%0d s=%0d c=%0d m=%0d o=%0b expected v=%0b r=%0d s=%0d c=%0d m=%0d o=%0b",
               $time, result_valid, result, score, combo, max_combo, overrun,
               m_rv, m_res, m_score, m_combo, m_max, m_ovr);
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    vectors = vectors + 1;
    if (actual != expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input bit p, input bit s, input bit c);
    push = p; spawn = s; clear = c;
    @(negedge clk);
  endtask

  // push_cnt < 0 lets the note expire; otherwise press when the tracked count equals push_cnt
  task automatic play_note(input int push_cnt);
    apply_stimulus(0, 1, 0);
    if (push_cnt >= 0) begin
      repeat (push_cnt) apply_stimulus(0, 0, 0);
      apply_stimulus(1, 0, 0);
    end else begin
      repeat (LEAD_CYC + GOOD_WIN + 1) apply_stimulus(0, 0, 0);
    end
  endtask

  initial begin
    apply_stimulus(0, 0, 0);
    check_output("reset_score", int'(score), 0);
    check_output("reset_valid", int'(result_valid), 0);
    check_output("reset_result", int'(result), 0);
    rst_n = 1'b1;
    repeat (2) apply_stimulus(0, 0, 0);

    play_note(20);
    check_output("t1_valid", int'(result_valid), 1);
    check_output("t1_result", int'(result), 1);
    check_output("t1_score", int'(score), 100);
    check_output("t1_combo", int'(combo), 1);
    apply_stimulus(0, 0, 0);
    check_output("t1_pulse_len", int'(result_valid), 0);

    play_note(17);
    check_output("t2_early_good", int'(result), 2);
    check_output("t2_score", int'(score), 150);
    apply_stimulus(0, 0, 0);
    play_note(25);
    check_output("t2_edge_good", int'(result), 2);
    check_output("t2_combo", int'(combo), 3);
    apply_stimulus(0, 0, 0);

    apply_stimulus(0, 1, 0);
    repeat (25) apply_stimulus(0, 0, 0);
    check_output("t3_no_early_miss", int'(result_valid), 0);
    apply_stimulus(0, 0, 0);
    check_output("t3_miss_valid", int'(result_valid), 1);
    check_output("t3_miss", int'(result), 3);
    check_output("t3_combo", int'(combo), 0);
    check_output("t3_max", int'(max_combo), 3);
    check_output("t3_score", int'(score), 200);
    apply_stimulus(0, 0, 0);

    apply_stimulus(0, 1, 0);
    repeat (10) apply_stimulus(0, 0, 0);
    apply_stimulus(1, 0, 0);
    check_output("t4_too_early", int'(result_valid), 0);
    repeat (10) apply_stimulus(0, 0, 0);
    apply_stimulus(1, 0, 0);
    check_output("t4_result", int'(result), 1);
    check_output("t4_score", int'(score), 300);
    apply_stimulus(0, 0, 0);

    apply_stimulus(0, 1, 0);
    repeat (2) apply_stimulus(0, 0, 0);
    apply_stimulus(0, 1, 0);
    check_output("t5_overrun", int'(overrun), 1);
    repeat (17) apply_stimulus(0, 0, 0);
    apply_stimulus(1, 1, 0);
    check_output("t5_result", int'(result), 1);
    check_output("t5_combo", int'(combo), 2);
    repeat (30) apply_stimulus(0, 0, 0);
    check_output("t5_single_result", int'(score), 400);
    apply_stimulus(1, 0, 0);
    check_output("t5_idle_push", int'(result_valid), 0);

    apply_stimulus(0, 1, 0);
    repeat (5) apply_stimulus(0, 0, 0);
    apply_stimulus(1, 1, 1);
    check_output("clear_score", int'(score), 0);
    check_output("clear_overrun", int'(overrun), 0);
    repeat (30) apply_stimulus(0, 0, 0);

    play_note(20);
    apply_stimulus(0, 1, 0);
    repeat (5) apply_stimulus(0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_output("t6_async_score", int'(score), 0);
    check_output("t6_async_combo", int'(combo), 0);
    check_output("t6_async_max", int'(max_combo), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) apply_stimulus(0, 0, 0);
    check_output("t6_no_miss", int'(result), 0);

    repeat (1030) begin
      play_note(20);
      apply_stimulus(0, 0, 0);
    end
    check_output("sat_score", int'(score), SCORE_MAX);
    check_output("sat_combo", int'(combo), COMBO_MAX);
    check_output("sat_max", int'(max_combo), COMBO_MAX);
    play_note(-1);
    check_output("sat_miss_combo", int'(combo), 0);
    check_output("sat_miss_max", int'(max_combo), COMBO_MAX);
    apply_stimulus(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
